// File: rtl/ram_loader.sv
// ram_loader: program-mode sequencer for the SAP RAM. Debounces the store and
// set-address buttons and emits one write strobe per store press, auto-incrementing the address.
`default_nettype none

module ram_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       prog_run,
    input  logic       key_store,
    input  logic       key_set_addr,
    input  logic [3:0] switch_enderecos,
    input  logic [7:0] switch_dados,
    output logic [3:0] prog_address,
    output logic [7:0] prog_data,
    output logic       prog_we,
    output logic [3:0] cur_address,
    output logic       busy,
    output logic       wrapped
);

    localparam int            CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        WRITE    = 3'd2,
        INC      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    logic [1:0] key_raw;
    logic [1:0] level;
    logic [1:0] press;

    assign key_raw = {key_set_addr, key_store};

    // Bit 0 is the store button, bit 1 the set-address button.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             lvl_q;
        logic             lvl_prev_q;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clock) begin
            if (clear) begin
                sync1_q    <= 1'b1;
                sync2_q    <= 1'b1;
                lvl_q      <= 1'b1;
                lvl_prev_q <= 1'b1;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= key_raw[i];
                sync2_q    <= sync1_q;
                lvl_prev_q <= lvl_q;
                if (sync2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign level[i] = lvl_q;
        assign press[i] = lvl_prev_q & ~lvl_q;
    end

    state_t     state_q;
    logic [3:0] addr_q;
    logic [3:0] addr_d;
    logic [7:0] data_q;
    logic       wrapped_q;

    assign addr_d = addr_q + 4'd1;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wrapped_q <= 1'b0;
        end else if (prog_run) begin
            // Run mode aborts any sequence without touching the address.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[1]) begin
                        state_q <= SET_ADDR;
                    end else if (press[0]) begin
                        state_q <= WRITE;
                        data_q  <= switch_dados;
                    end
                end
                SET_ADDR: begin
                    addr_q    <= switch_enderecos;
                    wrapped_q <= 1'b0;
                    state_q   <= WAIT_REL;
                end
                WRITE: begin
                    state_q <= INC;
                end
                INC: begin
                    addr_q <= addr_d;
                    if (addr_q == 4'hF) begin
                        wrapped_q <= 1'b1;
                    end
                    state_q <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (&level) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prog_we      = (state_q == WRITE) && !prog_run;
    assign busy         = (state_q != IDLE);
    assign prog_address = addr_q;
    assign cur_address  = addr_q;
    assign prog_data    = data_q;
    assign wrapped      = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// tb_ram_loader: table-driven, hand-written and randomized checks of ram_loader
// against a transaction-level model of address/wrap/write behaviour.
`default_nettype none

module tb_ram_loader;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       clear;
    logic       prog_run;
    logic       key_store;
    logic       key_set_addr;
    logic [3:0] switch_enderecos;
    logic [7:0] switch_dados;
    logic [3:0] prog_address;
    logic [7:0] prog_data;
    logic       prog_we;
    logic [3:0] cur_address;
    logic       busy;
    logic       wrapped;

    ram_loader #(.DEBOUNCE_CYCLES(N)) dut (
        .clock            (clock),
        .clear            (clear),
        .prog_run         (prog_run),
        .key_store        (key_store),
        .key_set_addr     (key_set_addr),
        .switch_enderecos (switch_enderecos),
        .switch_dados     (switch_dados),
        .prog_address     (prog_address),
        .prog_data        (prog_data),
        .prog_we          (prog_we),
        .cur_address      (cur_address),
        .busy             (busy),
        .wrapped          (wrapped)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        bit         is_store;
        logic [3:0] sw_a;
        logic [7:0] sw_d;
        logic [3:0] exp_waddr;
        logic [3:0] exp_cur;
        bit         exp_wrapped;
    } vec_t;

    wr_t  wr_q[$];
    logic prev_we = 1'b0;
    int   double_we = 0;
    int   total = 0;
    int   passed = 0;

    // Reference state: what the operator should see after each operation.
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
    bit         exp_wrapped;

    always begin
        @(negedge clock);
        #2;
        if (prog_we === 1'b1) begin
            wr_q.push_back('{prog_address, prog_data});
            if (prev_we) double_we++;
        end
        prev_we = (prog_we === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Press store and return the number of cycles until prog_we is seen (-1 if never).
    task automatic press_store(input logic [7:0] d, output int lat);
        @(negedge clock);
        switch_dados = d;
        key_store    = 1'b0;
        lat          = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            #1;
            if (prog_we === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_store(input logic [7:0] d, input string tag);
        int lat;
        press_store(d, lat);
        chk({tag, "_latency"}, lat, 7);
        wait_cycles(3);
        key_store = 1'b1;
        wait_cycles(N + 8);
        chk({tag, "_wr_count"}, wr_q.size(), 1);
        if (wr_q.size() >= 1) begin
            chk({tag, "_wr_addr"}, wr_q[0].a, exp_addr);
            chk({tag, "_wr_data"}, wr_q[0].d, d);
        end
        wr_q.delete();
        if (exp_addr == 4'hF) exp_wrapped = 1'b1;
        exp_addr = exp_addr + 4'd1;
        exp_data = d;
        chk({tag, "_cur"}, cur_address, exp_addr);
        chk({tag, "_wrapped"}, wrapped, exp_wrapped);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_set(input logic [3:0] a, input string tag);
        @(negedge clock);
        switch_enderecos = a;
        key_set_addr     = 1'b0;
        wait_cycles(N + 8);
        key_set_addr = 1'b1;
        wait_cycles(N + 8);
        exp_addr    = a;
        exp_wrapped = 1'b0;
        chk({tag, "_cur"}, cur_address, exp_addr);
        chk({tag, "_wrapped"}, wrapped, exp_wrapped);
        chk({tag, "_nowrite"}, wr_q.size(), 0);
        wr_q.delete();
    endtask

    initial begin
        vec_t tbl[7];
        int   lat;
        bit   flag;

        tbl[0] = '{0, 4'h3, 8'h00, 4'h0, 4'h3, 0};
        tbl[1] = '{1, 4'h0, 8'hA5, 4'h3, 4'h4, 0};
        tbl[2] = '{0, 4'hF, 8'h00, 4'h0, 4'hF, 0};
        tbl[3] = '{1, 4'h0, 8'h11, 4'hF, 4'h0, 1};
        tbl[4] = '{1, 4'h0, 8'h22, 4'h0, 4'h1, 1};
        tbl[5] = '{0, 4'h9, 8'h00, 4'h0, 4'h9, 0};
        tbl[6] = '{1, 4'h0, 8'h5A, 4'h9, 4'hA, 0};

        clear = 1'b1; prog_run = 1'b0; key_store = 1'b1; key_set_addr = 1'b1;
        switch_enderecos = '0; switch_dados = '0;
        wait_cycles(3);
        #1;
        chk("rst_we", prog_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur", cur_address, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_wrapped", wrapped, 0);
        clear = 1'b0;
        exp_addr = 4'h0; exp_data = 8'h00; exp_wrapped = 1'b0;
        wait_cycles(2);

        // Directed table of operations.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].is_store) begin
                press_store(tbl[i].sw_d, lat);
                chk("tbl_latency", lat, 7);
                wait_cycles(3);
                key_store = 1'b1;
                wait_cycles(N + 8);
                chk("tbl_wr_count", wr_q.size(), 1);
                if (wr_q.size() >= 1) begin
                    chk("tbl_wr_addr", wr_q[0].a, tbl[i].exp_waddr);
                    chk("tbl_wr_data", wr_q[0].d, tbl[i].sw_d);
                end
                wr_q.delete();
                exp_data = tbl[i].sw_d;
            end else begin
                do_set(tbl[i].sw_a, "tbl_set");
            end
            chk("tbl_cur", cur_address, tbl[i].exp_cur);
            chk("tbl_wrapped", wrapped, tbl[i].exp_wrapped);
            chk("tbl_busy", busy, 0);
            exp_addr    = tbl[i].exp_cur;
            exp_wrapped = tbl[i].exp_wrapped;
        end

        // Glitch of three cycles must not register.
        @(negedge clock);
        key_store = 1'b0;
        wait_cycles(3);
        key_store = 1'b1;
        flag = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock); #1;
            if (prog_we || busy) flag = 1;
        end
        chk("glitch_quiet", flag, 0);
        chk("glitch_nowrite", wr_q.size(), 0);
        chk("glitch_cur", cur_address, exp_addr);

        // Simultaneous press: set-address wins, store discarded.
        @(negedge clock);
        switch_enderecos = 4'h6; switch_dados = 8'h77;
        key_store = 1'b0; key_set_addr = 1'b0;
        wait_cycles(N + 10);
        key_store = 1'b1; key_set_addr = 1'b1;
        wait_cycles(N + 8);
        exp_addr = 4'h6; exp_wrapped = 1'b0;
        chk("simul_cur", cur_address, 4'h6);
        chk("simul_nowrite", wr_q.size(), 0);
        chk("simul_data", prog_data, exp_data);
        chk("simul_busy", busy, 0);
        wr_q.delete();

        // Run mode ignores presses.
        prog_run = 1'b1;
        @(negedge clock);
        switch_dados = 8'h99; key_store = 1'b0;
        flag = 0;
        for (int i = 0; i < N + 10; i++) begin
            @(negedge clock); #1;
            if (busy || prog_we) flag = 1;
        end
        key_store = 1'b1;
        wait_cycles(N + 8);
        prog_run = 1'b0;
        wait_cycles(2);
        chk("run_quiet", flag, 0);
        chk("run_nowrite", wr_q.size(), 0);
        chk("run_cur", cur_address, exp_addr);
        chk("run_data", prog_data, exp_data);

        // Run mode during WAIT_REL: return to IDLE, address keeps its increment.
        press_store(8'h42, lat);
        chk("wr_latency", lat, 7);
        wait_cycles(3);
        #1;
        chk("wr_busy_before", busy, 1);
        exp_addr = exp_addr + 4'd1;
        exp_data = 8'h42;
        prog_run = 1'b1;
        @(negedge clock); #1;
        chk("wr_busy_after", busy, 0);
        chk("wr_cur", cur_address, exp_addr);
        key_store = 1'b1;
        wait_cycles(N + 8);
        prog_run = 1'b0;
        wait_cycles(2);
        chk("wr_wr_count", wr_q.size(), 1);
        chk("wr_cur_final", cur_address, exp_addr);
        wr_q.delete();

        // Run mode rising exactly when WRITE is entered.
        @(negedge clock);
        switch_dados = 8'h3C; key_store = 1'b0;
        wait_cycles(6);
        @(negedge clock);
        prog_run = 1'b1;
        #1;
        chk("we_entry_busy", busy, 1);
        chk("we_entry_we", prog_we, 0);
        @(negedge clock); #1;
        chk("we_entry_idle", busy, 0);
        key_store = 1'b1;
        wait_cycles(N + 8);
        prog_run = 1'b0;
        wait_cycles(2);
        exp_data = 8'h3C;
        chk("we_entry_nowrite", wr_q.size(), 0);
        chk("we_entry_cur", cur_address, exp_addr);
        chk("we_entry_data", prog_data, exp_data);
        wr_q.delete();

        // Reset in the middle of a write.
        press_store(8'hE7, lat);
        chk("rstw_latency", lat, 7);
        clear = 1'b1; key_store = 1'b1;
        @(negedge clock); #1;
        chk("rstw_we", prog_we, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_cur", cur_address, 0);
        chk("rstw_data", prog_data, 0);
        chk("rstw_wrapped", wrapped, 0);
        wait_cycles(4);
        clear = 1'b0;
        wait_cycles(N + 8);
        chk("rstw_busy_later", busy, 0);
        wr_q.delete();
        exp_addr = 4'h0; exp_data = 8'h00; exp_wrapped = 1'b0;

        // Randomized operations against the transaction model.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_set(4'($urandom_range(12, 15)), "rnd_set");
            end else begin
                do_store(8'($urandom), "rnd_store");
            end
        end

        chk("no_back_to_back_we", double_we, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
